// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the 4-digit seven-segment scan controller.
//   SEG7_NUM_DIGITS : digits scanned per frame
//   SEG7_SEG_BLANK  : a..g pattern with every segment dark (active-low)
//   SEG7_AN_OFF     : anode pattern with every digit disabled (active-low)
package seg7_pkg;

    localparam int SEG7_NUM_DIGITS = 4;
    localparam logic [6:0] SEG7_SEG_BLANK = 7'b1111111;
    localparam logic [3:0] SEG7_AN_OFF = 4'b1111;

    // Active-low one-hot anode enable for digit position idx.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder -- hex nibble to seven-segment pattern, active-low.
//   in     : hex digit 0..F
//   a_to_g : segments {a,b,c,d,e,f,g}, bit 6 = a, 0 = segment lit
module seg7_decoder (
    input  logic [3:0] in,
    output logic [6:0] a_to_g
);

    always_comb begin
        a_to_g = 7'b1111111;
        case (in)
            4'h0: a_to_g = 7'b0000001;
            4'h1: a_to_g = 7'b1001111;
            4'h2: a_to_g = 7'b0010010;
            4'h3: a_to_g = 7'b0000110;
            4'h4: a_to_g = 7'b1001100;
            4'h5: a_to_g = 7'b0100100;
            4'h6: a_to_g = 7'b0100000;
            4'h7: a_to_g = 7'b0001111;
            4'h8: a_to_g = 7'b0000000;
            4'h9: a_to_g = 7'b0000100;
            4'hA: a_to_g = 7'b0001000;
            4'hB: a_to_g = 7'b1100000;
            4'hC: a_to_g = 7'b0110001;
            4'hD: a_to_g = 7'b1000010;
            4'hE: a_to_g = 7'b0110000;
            4'hF: a_to_g = 7'b0111000;
            default: a_to_g = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- time-multiplexed 4-digit seven-segment driver with
// frame-synchronous update (new data only appears at a frame boundary).
//   clk, rst    : clock, synchronous active-high reset
//   value       : four hex nibbles, nibble k on digit k (digit 0 rightmost)
//   dp_in       : decimal point request per digit, 1 = lit
//   load        : one-cycle strobe capturing value/dp_in
//   upd_pending : loaded data waiting for the next frame boundary
//   frame_tick  : one-cycle pulse on each frame boundary (commit)
//   an          : digit enables, active-low
//   a_to_g      : segments a..g, active-low
//   dp          : decimal point, active-low
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits 1..3 (digit 0 always shown; a lit decimal point stops blanking).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int NUM_DIGITS = SEG7_NUM_DIGITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        upd_pending,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [6:0]  a_to_g,
    output logic        dp
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic          tick;
    logic          commit;
    logic [3:0]    cur_nib;
    logic [6:0]    seg_dec;

    assign tick       = (cnt == CW'(CLK_DIV - 1));
    assign commit     = tick && (idx == IW'(NUM_DIGITS - 1));
    assign frame_tick = commit && !rst;
    assign cur_nib    = shadow_val[idx*4 +: 4];

    seg7_decoder u_dec (
        .in     (cur_nib),
        .a_to_g (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            upd_pending <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                idx <= idx + IW'(1);
            // A load on the commit edge bypasses pending and lands in the
            // shadow directly, so it is never reported as pending.
            if (commit) begin
                if (load) begin
                    shadow_val <= value;
                    shadow_dp  <= dp_in;
                    pend_val   <= value;
                    pend_dp    <= dp_in;
                end else if (upd_pending) begin
                    shadow_val <= pend_val;
                    shadow_dp  <= pend_dp;
                end
                upd_pending <= 1'b0;
            end else if (load) begin
                pend_val    <= value;
                pend_dp     <= dp_in;
                upd_pending <= 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic blank;
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1: blank = (shadow_val[15:4]  == 12'h000) && !shadow_dp[1];
            2'd2: blank = (shadow_val[15:8]  == 8'h00)   && !shadow_dp[2];
            2'd3: blank = (shadow_val[15:12] == 4'h0)    && !shadow_dp[3];
            default: blank = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            an     <= SEG7_AN_OFF;
            a_to_g <= SEG7_SEG_BLANK;
            dp     <= 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        end else if (blank) begin
            an     <= SEG7_AN_OFF;
            a_to_g <= SEG7_SEG_BLANK;
            dp     <= 1'b1;
`endif
        end else begin
            an     <= anode_for(idx);
            a_to_g <= seg_dec;
            dp     <= ~shadow_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl -- self-checking bench for seg7_scan_ctrl (CLK_DIV=4).
// Reference model works from elapsed cycles since reset: digit slot and frame
// boundary come from integer division of that count; segment patterns come
// from the list of lit segments per hex digit.
// Define SEG7_LEADING_ZERO_BLANK_EN to build and check the blanking variant.
module tb_seg7_scan_ctrl;

    localparam int D = 4;
    localparam int F = 4 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        upd_pending;
    logic        frame_tick;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;

    seg7_scan_ctrl #(.CLK_DIV(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp_in       (dp_in),
        .load        (load),
        .upd_pending (upd_pending),
        .frame_tick  (frame_tick),
        .an          (an),
        .a_to_g      (a_to_g),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    int          t = 0;
    logic [15:0] m_sh = '0, m_pend = '0;
    logic [3:0]  m_shdp = '0, m_penddp = '0;
    bit          m_flag = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    string seg_lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] r;
        string s;
        int b;
        r = 7'h7F;
        s = seg_lit[n];
        for (int i = 0; i < s.len(); i++) begin
            b = int'(s[i]) - 97;
            r[6 - b] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic ft;
        ft = !rst && ((t % F) == F - 1);
        return {e_an, e_seg, e_dp, m_flag, ft};
    endfunction

    wire [13:0] obs = {an, a_to_g, dp, upd_pending, frame_tick};

    task automatic model_edge(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        int k;
        bit last;
        bit blank;
        if (r) begin
            t = 0; m_sh = '0; m_shdp = '0; m_pend = '0; m_penddp = '0; m_flag = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            k = (t / D) % 4;
            last = ((t % F) == F - 1);
            blank = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank = (k > 0) && ((m_sh >> (4 * k)) == 16'h0) && !m_shdp[k];
`endif
            if (blank) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = 4'hF;
                e_an[k] = 1'b0;
                e_seg = ref_seg(4'((m_sh >> (4 * k)) & 16'hF));
                e_dp = ~m_shdp[k];
            end
            if (last && l) begin
                m_sh = v; m_shdp = d; m_flag = 0;
            end else if (last) begin
                if (m_flag) begin m_sh = m_pend; m_shdp = m_penddp; end
                m_flag = 0;
            end else if (l) begin
                m_pend = v; m_penddp = d; m_flag = 1;
            end
            t++;
        end
    endtask

    task automatic cycle(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        rst = r; load = l; value = v; dp_in = d;
        @(posedge clk);
        model_edge(r, l, v, d);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, (i == 1), 16'hFFFF, 4'hF);
            tests++;
            if ({an, a_to_g, dp, upd_pending, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset_dark got %b want %b", obs, {4'b1111, 7'b1111111, 3'b100});
            end
        end
    endtask

    task automatic test_idle_scan();
        int nft = 0;
        for (int i = 0; i < 2 * F; i++) begin
            cycle(0, 0, 16'h0, 4'h0);
            if (frame_tick === 1'b1) nft++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL idle_scan t=%0d got %b want %b", t, obs, exp_vec());
            end
        end
        tests++;
        if (nft != 2) begin
            fails++;
            $display("FAIL idle_frame_ticks got %0d want 2", nft);
        end
    endtask

    task automatic test_mid_load();
        for (int i = 0; i < F && (t % F) != 5; i++) cycle(0, 0, value, dp_in);
        cycle(0, 1, 16'h1234, 4'h0);
        tests++;
        if (upd_pending !== 1'b1) begin
            fails++;
            $display("FAIL mid_load_pending got %b want 1", upd_pending);
        end
        for (int i = 0; i < 2 * F + 3; i++) begin
            cycle(0, 0, value, dp_in);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL mid_load t=%0d got %b want %b", t, obs, exp_vec());
            end
        end
    endtask

    task automatic test_last_wins();
        int seen_a = 0;
        for (int i = 0; i < F && (t % F) != 2; i++) cycle(0, 0, value, dp_in);
        cycle(0, 1, 16'hAAAA, 4'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, value, dp_in);
        cycle(0, 1, 16'h5555, 4'h0);
        for (int i = 0; i < 2 * F; i++) begin
            cycle(0, 0, value, dp_in);
            if (a_to_g === ref_seg(4'hA)) seen_a++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL last_wins t=%0d got %b want %b", t, obs, exp_vec());
            end
        end
        tests++;
        if (seen_a != 0) begin
            fails++;
            $display("FAIL last_wins_no_A got %0d cycles showing A want 0", seen_a);
        end
    endtask

    task automatic test_load_on_commit();
        int saw_up = 0;
        for (int i = 0; i < F && (t % F) != F - 1; i++) cycle(0, 0, value, dp_in);
        cycle(0, 1, 16'hBEEF, 4'h0);
        for (int i = 0; i < F + 2; i++) begin
            if (upd_pending === 1'b1) saw_up++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL commit_load t=%0d got %b want %b", t, obs, exp_vec());
            end
            cycle(0, 0, value, dp_in);
        end
        tests++;
        if (saw_up != 0) begin
            fails++;
            $display("FAIL commit_load_pending got %0d cycles high want 0", saw_up);
        end
    endtask

    task automatic test_rst_mid_frame();
        for (int i = 0; i < F && (t % F) != 1; i++) cycle(0, 0, value, dp_in);
        cycle(0, 1, 16'h9999, 4'hF);
        for (int i = 0; i < F && ((t / D) % 4) != 2; i++) cycle(0, 0, value, dp_in);
        cycle(1, 1, 16'h4321, 4'h0);
        tests++;
        if ({an, a_to_g, dp, upd_pending} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid_dark got %b want %b", obs[13:1], {4'b1111, 7'b1111111, 2'b10});
        end
        for (int i = 0; i < F + 2; i++) begin
            cycle(0, 0, value, dp_in);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rst_mid_after t=%0d got %b want %b", t, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic r, l;
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 4) == 0);
            cycle(r, l, 16'($urandom), 4'($urandom));
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random i=%0d got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    task automatic test_blank();
        cycle(1, 0, 16'h0, 4'h0);
        cycle(0, 1, 16'h0007, 4'h0);
        for (int i = 0; i < 2 * F; i++) begin
            cycle(0, 0, value, dp_in);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL blank_0007 t=%0d got %b want %b", t, obs, exp_vec());
            end
        end
        cycle(0, 1, 16'h0007, 4'b0100);
        for (int i = 0; i < 2 * F; i++) begin
            cycle(0, 0, value, dp_in);
            if (an === 4'b1011) begin
                tests++;
                if ({a_to_g, dp} !== {7'b0000001, 1'b0}) begin
                    fails++;
                    $display("FAIL blank_dp_digit2 got %b want %b", {a_to_g, dp}, 8'b00000010);
                end
            end
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL blank_dp t=%0d got %b want %b", t, obs, exp_vec());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_mid_load();
        test_last_wins();
        test_load_on_commit();
        test_rst_mid_frame();
        test_random();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per digit slot (legal >= 2).
REQ-002 Parameter NUM_DIGITS, fixed 4, digits scanned per frame.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 value  input  16  four hex nibbles; nibble k shows on digit k, digit 0 rightmost.
REQ-006 dp_in  input  4  decimal point request per digit, 1 = lit.
REQ-007 load  input  1  one-cycle strobe capturing value/dp_in into pending register.
REQ-008 upd_pending  output  1  high from the cycle after load until that data is committed.
REQ-009 frame_tick  output  1  one-cycle pulse on each commit boundary.
REQ-010 an  output  4  digit enables, active-low, one-hot-low when driven.
REQ-011 a_to_g  output  7  segments a..g, active-low, taken from seg7_decoder.
REQ-012 dp  output  1  decimal point, active-low.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1, wraps to 0; tick asserted in the cycle it equals CLK_DIV-1.
REQ-014 Digit index idx (2 bits) increments on tick, 3 wraps to 0.
REQ-015 Commit boundary: tick with idx==3; pending copies into display shadow; frame_tick high that cycle.
REQ-016 load with no commit: pending <= value/dp_in, upd_pending set next cycle.
REQ-017 load coincident with commit: new load data goes straight to shadow; upd_pending cleared next cycle.
REQ-018 Multiple loads before commit: last load wins, earlier ones dropped silently.
REQ-019 Commit with no pending load: shadow unchanged, frame_tick still pulses.
REQ-020 an, a_to_g, dp registered, one-cycle latency after idx or shadow change.
REQ-021 Driven state: an bit idx low, others high; a_to_g = decode(shadow nibble idx); dp = ~shadow_dp[idx].
REQ-022 Display never shows mixed old/new nibbles within one frame (shadow only changes at commit).

Reset
REQ-023 rst: prescaler 0, idx 0, pending 0, shadow 0, upd_pending 0, frame_tick 0.
REQ-024 Outputs on reset cycle: an=4'b1111, a_to_g=7'b1111111, dp=1 (all dark).
REQ-025 rst mid-frame discards pending and shadow; first digit drive is idx 0 in the cycle after rst deasserts.
REQ-026 rst dominates a simultaneous load.

Configuration
REQ-027 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digit k (k=1..3) blanked (an bit high, a_to_g=7'b1111111) when shadow nibbles k..3 all zero and shadow_dp[k]==0; digit 0 never blanked.
REQ-028 Macro undefined: no blanking; all four digits always driven per REQ-021; no blanking logic synthesised.

Structure
REQ-029 Shared package seg7_pkg holds NUM_DIGITS, segment blank constant 7'b1111111, anode-off constant 4'b1111.
REQ-030 Instantiates one seg7_decoder (in[3:0] -> a_to_g[6:0]) fed by muxed shadow nibble; no other sub-modules.
REQ-031 Prescaler, idx, pending/shadow registers, commit logic in seg7_scan_ctrl itself.

Verification (CLK_DIV=4)
REQ-032 Reset 3 cycles then release, no load -> an cycles 1110,1101,1011,0111 every 4 clocks, a_to_g=decode(0), frame_tick every 16 clocks.
REQ-033 load value=16'h1234 mid-frame -> upd_pending high until next commit, then digits 0..3 show 4,3,2,1; no earlier frame shows mixed data.
REQ-034 load 16'hAAAA then 16'h5555 in same frame -> only 5 ever displayed; A never appears.
REQ-035 load 16'hBEEF exactly on commit cycle -> shown from following frame, upd_pending never asserted.
REQ-036 rst asserted during digit 2 with pending load -> outputs dark next cycle; after release shows 0, upd_pending 0.
REQ-037 SEG7_LEADING_ZERO_BLANK_EN defined, value=16'h0007, dp_in=0 -> digits 3..1 an high, digit 0 shows 7; with dp_in=4'b0100 digit 2 drives '0' with dp lit.
